// File: rtl/adder_result_fifo.sv
// Result FIFO behind the 32-bit adder: valid/ready push side, Wishbone classic pop side.
// Optional threshold interrupt is built only when ADDER_RESULT_FIFO_IRQ_EN is defined.
module adder_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              irq
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic              r_udf;
  logic              r_ack;
  logic [31:0]       r_dat;

  logic        w_acc;
  logic [1:0]  w_addr;
  logic        w_rd;
  logic        w_wr;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_ovf_evt;
  logic        w_udf_evt;
  logic        w_flush;
  logic        w_clr;
  logic [31:0] w_status;
  logic [31:0] w_thresh_rd;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_acc   = wbs_cyc_i && wbs_stb_i && !r_ack;
  assign w_addr  = wbs_adr_i[3:2];
  assign w_rd    = w_acc && !wbs_we_i;
  assign w_wr    = w_acc && wbs_we_i;
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  assign w_push    = s_valid && !w_full;
  assign w_pop     = w_rd && (w_addr == 2'd0) && !w_empty;
  assign w_ovf_evt = s_valid && w_full;
  assign w_udf_evt = w_rd && (w_addr == 2'd0) && w_empty;
  assign w_flush   = w_wr && (w_addr == 2'd2) && wbs_dat_i[0];
  assign w_clr     = w_wr && (w_addr == 2'd2) && wbs_dat_i[1];

  assign s_ready   = !w_full;
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  // Byte selects and high address bits are don't-care for full-word access.
  assign w_unused = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    w_status         = '0;
    w_status[AW:0]   = r_count;
    w_status[16]     = w_empty;
    w_status[17]     = w_full;
    w_status[18]     = r_ovf;
    w_status[19]     = r_udf;
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      2'd0: if (!w_empty) w_rdata = 32'(r_mem[r_rd_ptr]);
      2'd1: w_rdata = w_status;
      2'd3: w_rdata = w_thresh_rd;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push && !w_flush) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_ack <= w_acc;
      if (w_acc) r_dat <= wbs_we_i ? 32'd0 : w_rdata;

      // Flush wins over any push landing on the same edge.
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end

      if (w_ovf_evt)  r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
      if (w_udf_evt)  r_udf <= 1'b1;
      else if (w_clr) r_udf <= 1'b0;
    end
  end

`ifdef ADDER_RESULT_FIFO_IRQ_EN
  logic [AW:0] r_thresh;
  logic        r_irq;

  assign w_thresh_rd = 32'(r_thresh);
  assign irq         = r_irq;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_thresh <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_addr == 2'd3)) r_thresh <= wbs_dat_i[AW:0];
      // Evaluated from registered state, so irq trails the causing edge by one cycle.
      r_irq <= ((r_thresh != '0) && (r_count >= r_thresh)) || r_ovf;
    end
  end
`else
  assign w_thresh_rd = '0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Self-checking bench for adder_result_fifo: vector table, directed corner cases and
// randomized traffic against a queue-based model of the register map.
module tb_adder_result_fifo;
  localparam int DEPTH = 8;
`ifdef ADDER_RESULT_FIFO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, dat_i = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        irq;

  always #5 clk = ~clk;

  adder_result_fifo #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),    .wb_rst_ni(rst_n),
    .s_valid  (s_valid), .s_data  (s_data), .s_ready(s_ready),
    .wbs_cyc_i(cyc),    .wbs_stb_i(stb),   .wbs_we_i(we),
    .wbs_sel_i(sel),    .wbs_adr_i(adr),   .wbs_dat_i(dat_i),
    .wbs_ack_o(ack),    .wbs_dat_o(dat_o), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: FIFO contents as a queue plus the two sticky flags and threshold.
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0, m_udf = 1'b0;
  logic [31:0] m_thresh = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    n = mq.size();
    s = '0;
    s[3:0] = 4'(n);
    s[16]  = (n == 0);
    s[17]  = (n == DEPTH);
    s[18]  = m_ovf;
    s[19]  = m_udf;
    return s;
  endfunction

  function automatic void m_push(input logic [31:0] d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1'b1;
  endfunction

  // One bus access, with an optional push beat landing on the same edge.
  function automatic logic [31:0] m_access(input bit w, input int a, input logic [31:0] wd,
                                           input bit pv, input logic [31:0] pd);
    int pre;
    logic [31:0] r;
    bit ovf_e, udf_e, flush, clr;
    pre = mq.size();
    r = '0; udf_e = 0; flush = 0; clr = 0;
    ovf_e = pv && (pre == DEPTH);
    if (!w) begin
      case (a)
        0: if (pre == 0) udf_e = 1; else r = mq.pop_front();
        1: r = m_status();
        3: r = IRQ_EN ? m_thresh : 32'd0;
        default: r = '0;
      endcase
    end else begin
      if (a == 2) begin flush = wd[0]; clr = wd[1]; end
      if (a == 3 && IRQ_EN) m_thresh = wd & 32'hF;
    end
    if (flush) mq.delete();
    else if (pv && pre < DEPTH) mq.push_back(pd);
    if (clr) begin m_ovf = 0; m_udf = 0; end
    if (ovf_e) m_ovf = 1;
    if (udf_e) m_udf = 1;
    return r;
  endfunction

  task automatic do_push(input logic [31:0] d);
    @(negedge clk);
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
    m_push(d);
    $display("push 0x%08h", d);
  endtask

  task automatic wb(input bit w, input int a, input logic [31:0] wd,
                    input bit pv, input logic [31:0] pd, output logic [31:0] rd);
    int k;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = 32'(a) << 2; dat_i = wd;
    s_valid = pv; s_data = pd;
    @(negedge clk);
    s_valid = 1'b0;
    k = 0;
    while (!ack && k < 8) begin @(negedge clk); k++; end
    check("wb_ack", {31'd0, ack}, 32'd1);
    rd = dat_o;
    cyc = 0; stb = 0; we = 0;
    $display("wb %s adr=%0d wdat=0x%08h push=%0d rdat=0x%08h", w ? "wr" : "rd", a, wd, pv, rd);
  endtask

  // Bus access checked against the model (reads only).
  task automatic acc(input string name, input bit w, input int a, input logic [31:0] wd,
                     input bit pv, input logic [31:0] pd, output logic [31:0] rd);
    logic [31:0] want;
    wb(w, a, wd, pv, pd, rd);
    want = m_access(w, a, wd, pv, pd);
    if (!w) check(name, rd, want);
  endtask

  typedef struct {
    int          op;    // 0 push, 1 read, 2 write
    int          a;
    logic [31:0] d;
    logic [31:0] want;
  } vec_t;

  initial begin
    vec_t tbl[12];
    logic [31:0] r;
    int nacks;

    tbl[0]  = '{0, 0, 32'h11, 0};
    tbl[1]  = '{0, 0, 32'h22, 0};
    tbl[2]  = '{0, 0, 32'h33, 0};
    tbl[3]  = '{1, 0, 0, 32'h11};
    tbl[4]  = '{1, 0, 0, 32'h22};
    tbl[5]  = '{1, 0, 0, 32'h33};
    tbl[6]  = '{1, 1, 0, 32'h0001_0000};
    tbl[7]  = '{1, 0, 0, 32'h0};
    tbl[8]  = '{1, 1, 0, 32'h0009_0000};
    tbl[9]  = '{2, 2, 32'h2, 0};
    tbl[10] = '{1, 1, 0, 32'h0001_0000};
    tbl[11] = '{1, 2, 0, 32'h0};

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      case (tbl[i].op)
        0: do_push(tbl[i].d);
        1: begin
          wb(0, tbl[i].a, 0, 0, 0, r);
          void'(m_access(0, tbl[i].a, 0, 0, 0));
          check($sformatf("tbl%0d", i), r, tbl[i].want);
        end
        default: begin
          wb(1, tbl[i].a, tbl[i].d, 0, 0, r);
          void'(m_access(1, tbl[i].a, tbl[i].d, 0, 0));
        end
      endcase
    end

    // Fill to full, then overflow with 0xDEAD.
    for (int i = 0; i < DEPTH; i++) do_push($urandom() & 32'hFFFF);
    check("full_ready", {31'd0, s_ready}, 32'd0);
    do_push(32'hDEAD);
    acc("full_status", 0, 1, 0, 0, 0, r);
    check("full_status_const", r, 32'h0006_0008);
    for (int i = 0; i < DEPTH; i++) begin
      acc("drain", 0, 0, 0, 0, 0, r);
      check("no_dead", {31'd0, r == 32'hDEAD}, 32'd0);
    end
    acc("empty_read", 0, 0, 0, 0, 0, r);
    check("empty_read_zero", r, 32'd0);
    acc("udf_status", 0, 1, 0, 0, 0, r);
    acc("clr", 1, 2, 32'h2, 0, 0, r);
    acc("clr_status", 0, 1, 0, 0, 0, r);
    check("clr_status_const", r, 32'h0001_0000);

    // Simultaneous push and pop at count 3 across a pointer wrap.
    for (int i = 0; i < 3; i++) do_push($urandom());
    for (int i = 0; i < 10; i++) acc("sim_pop", 0, 0, 0, 1, $urandom(), r);
    acc("sim_status", 0, 1, 0, 0, 0, r);
    check("sim_count3", r & 32'hF, 32'd3);
    acc("flush", 1, 2, 32'h3, 0, 0, r);
    acc("sim_empty_pop", 0, 0, 0, 1, 32'h5A5A, r);
    acc("sim_empty_status", 0, 1, 0, 0, 0, r);
    check("sim_empty_const", r, 32'h0008_0001);

    // Flush at count 5 with a push on the same edge.
    acc("flush2", 1, 2, 32'h3, 0, 0, r);
    for (int i = 0; i < 5; i++) do_push($urandom());
    acc("flush_push", 1, 2, 32'h1, 1, 32'hBEEF, r);
    acc("flush_status", 0, 1, 0, 0, 0, r);
    check("flush_count0", r, 32'h0001_0000);
    acc("flush_read", 0, 0, 0, 0, 0, r);
    acc("flush_udf", 0, 1, 0, 0, 0, r);

    // Threshold register and interrupt.
    acc("clr3", 1, 2, 32'h3, 0, 0, r);
    acc("thr_wr", 1, 3, 32'h4, 0, 0, r);
    acc("thr_rd", 0, 3, 0, 0, 0, r);
    for (int i = 0; i < 3; i++) do_push($urandom());
    repeat (2) @(negedge clk);
    check("irq_cnt3", {31'd0, irq}, 32'd0);
    do_push($urandom());
    @(negedge clk);
    check("irq_cnt4", {31'd0, irq}, {31'd0, IRQ_EN});
    acc("irq_pop", 0, 0, 0, 0, 0, r);
    repeat (2) @(negedge clk);
    check("irq_after_pop", {31'd0, irq}, 32'd0);
    acc("thr_zero", 1, 3, 32'h0, 0, 0, r);

    // Held strobe: acks on every other cycle.
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h4;
    nacks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) nacks++;
    end
    cyc = 0; stb = 0;
    check("b2b_acks", 32'(nacks), 32'd3);
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_push($urandom());
        4, 5: acc("rnd_data", 0, 0, 0, 0, 0, r);
        6: acc("rnd_data_push", 0, 0, 0, 1, $urandom(), r);
        7: acc("rnd_status", 0, 1, 0, 0, 0, r);
        8: acc("rnd_ctrl", 1, 2, 32'($urandom_range(0, 3)), 0, 0, r);
        default: acc("rnd_wr_ro", 1, $urandom_range(0, 1), $urandom(), 0, 0, r);
      endcase
    end

    // Reset asserted while an ack is high.
    do_push(32'h77);
    do_push(32'h88);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h4;
    @(posedge clk);
    #2;
    check("ack_before_rst", {31'd0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ack_async_drop", {31'd0, ack}, 32'd0);
    check("dat_async_clear", dat_o, 32'd0);
    check("ready_after_rst", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    cyc = 0; stb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_ovf = 0; m_udf = 0; m_thresh = '0;
    acc("post_rst_status", 0, 1, 0, 0, 0, r);
    check("post_rst_const", r, 32'h0001_0000);
    acc("post_rst_thresh", 0, 3, 0, 0, 0, r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
